// File: rtl/sram_pingpong_arb.sv
// ---------------------------------------------------------------------------
// sram_pingpong_arb
//
// Ping-pong frame buffer controller in front of one single-port SRAM that
// holds two frame banks. A raster-order write stream fills the write bank
// while a random-access reader consumes the other (read) bank. When the
// write bank is full and the reader has released its frame, the banks swap.
// Only one SRAM access happens per cycle. A round-robin pointer arbitrates
// between the writer and the reader when both want the SRAM in the same cycle.
//
// Parameters
//   WD     data / pixel width
//   FRAME  words per frame bank (power of two)
//   WF     frame-local address width; the SRAM address is WF+1 bits wide
//
// Ports
//   clk_i            clock, all logic on the rising edge
//   rstn_i           synchronous active-low reset
//   wr_vld_i         write stream pixel valid
//   wr_rdy_o         write pixel accepted this cycle (write grant)
//   wr_data_i        write stream pixel, raster order
//   rd_req_i         reader access request
//   rd_addr_i        reader frame-local address
//   rd_gnt_o         reader request granted this cycle
//   rd_data_o        read data, valid while rd_dvld_o is high
//   rd_dvld_o        read data valid, one cycle after rd_gnt_o
//   rd_frame_done_i  one-cycle pulse: reader finished with the read frame
//   frm_rdy_o        read bank holds a complete frame
//   bank_sel_o       current write bank (read bank is the other one)
//   mem_cs_o         SRAM chip select
//   mem_we_o         SRAM write enable
//   mem_addr_o       SRAM address {bank, local address}
//   mem_din_o        SRAM write data
//   mem_dout_i       SRAM read data, valid the cycle after a read access
// ---------------------------------------------------------------------------
module sram_pingpong_arb #(
    parameter int WD    = 8,
    parameter int FRAME = 256 * 256,
    parameter int WF    = $clog2(FRAME)
) (
    input  logic          clk_i,
    input  logic          rstn_i,

    input  logic          wr_vld_i,
    output logic          wr_rdy_o,
    input  logic [WD-1:0] wr_data_i,

    input  logic          rd_req_i,
    input  logic [WF-1:0] rd_addr_i,
    output logic          rd_gnt_o,
    output logic [WD-1:0] rd_data_o,
    output logic          rd_dvld_o,
    input  logic          rd_frame_done_i,

    output logic          frm_rdy_o,
    output logic          bank_sel_o,

    output logic          mem_cs_o,
    output logic          mem_we_o,
    output logic [WF:0]   mem_addr_o,
    output logic [WD-1:0] mem_din_o,
    input  logic [WD-1:0] mem_dout_i
);

    // Counter is one bit wider than the local address so it can hold FRAME.
    localparam int            CNT_W    = WF + 1;
    localparam logic [WF:0]   CNT_LAST = CNT_W'(FRAME - 1);

    // Write-side state: filling the write bank, or holding a full bank
    // until the reader releases the other one.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } wstate_e;

    // -----------------------------------------------------------------------
    // Registered state
    // -----------------------------------------------------------------------
    wstate_e     wstate_q, wstate_d;
    logic [WF:0] wcnt_q, wcnt_d;
    logic        bank_sel_q, bank_sel_d;
    logic        frm_rdy_q, frm_rdy_d;
    logic        rd_dvld_q, rd_dvld_d;
    // Contention pointer: 0 = reader wins the next tie, 1 = writer wins it.
    logic        wr_prio_q, wr_prio_d;

    // -----------------------------------------------------------------------
    // Arbitration (combinational from registered state and inputs)
    // -----------------------------------------------------------------------
    logic wr_elig;
    logic rd_elig;
    logic wr_gnt;
    logic rd_gnt;
    logic swap;

    always_comb begin
        wr_elig = 1'b0;
        rd_elig = 1'b0;
        wr_gnt  = 1'b0;
        rd_gnt  = 1'b0;

        if (rstn_i) begin
            wr_elig = wr_vld_i && (wstate_q == ST_FILL);
            rd_elig = rd_req_i && frm_rdy_q;
        end

        if (wr_elig && rd_elig) begin
            wr_gnt = wr_prio_q;
            rd_gnt = !wr_prio_q;
        end else begin
            wr_gnt = wr_elig;
            rd_gnt = rd_elig;
        end
    end

    // A full bank swaps only once the reader has released its frame. Both
    // terms are registered, so a write that just completed the frame, or a
    // frame-done pulse in this cycle, can only take effect one cycle later.
    assign swap = (wstate_q == ST_FULL) && !frm_rdy_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        wstate_d   = wstate_q;
        wcnt_d     = wcnt_q;
        bank_sel_d = bank_sel_q;
        frm_rdy_d  = frm_rdy_q;
        wr_prio_d  = wr_prio_q;
        rd_dvld_d  = rd_gnt;

        case (wstate_q)
            ST_FILL: begin
                if (wr_gnt) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == CNT_LAST) begin
                        wstate_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (swap) begin
                    wstate_d   = ST_FILL;
                    wcnt_d     = '0;
                    bank_sel_d = !bank_sel_q;
                end
            end
            default: begin
                wstate_d = ST_FILL;
            end
        endcase

        // Swap and frame release are exclusive: swap needs frm_rdy_q low,
        // release needs it high.
        if (swap) begin
            frm_rdy_d = 1'b1;
        end else if (rd_frame_done_i && frm_rdy_q) begin
            frm_rdy_d = 1'b0;
        end

        // Move the pointer only when both sides actually contended.
        if (wr_elig && rd_elig) begin
            wr_prio_d = rd_gnt;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wstate_q   <= ST_FILL;
            wcnt_q     <= '0;
            bank_sel_q <= 1'b0;
            frm_rdy_q  <= 1'b0;
            rd_dvld_q  <= 1'b0;
            wr_prio_q  <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            wcnt_q     <= wcnt_d;
            bank_sel_q <= bank_sel_d;
            frm_rdy_q  <= frm_rdy_d;
            rd_dvld_q  <= rd_dvld_d;
            wr_prio_q  <= wr_prio_d;
        end
    end

    // -----------------------------------------------------------------------
    // SRAM port
    // -----------------------------------------------------------------------
    always_comb begin
        mem_cs_o   = wr_gnt || rd_gnt;
        mem_we_o   = wr_gnt;
        mem_din_o  = wr_data_i;
        mem_addr_o = '0;
        if (wr_gnt) begin
            mem_addr_o = {bank_sel_q, wcnt_q[WF-1:0]};
        end else if (rd_gnt) begin
            mem_addr_o = {!bank_sel_q, rd_addr_i};
        end
    end

    // -----------------------------------------------------------------------
    // Stream-side outputs
    // -----------------------------------------------------------------------
    assign wr_rdy_o   = wr_gnt;
    assign rd_gnt_o   = rd_gnt;
    assign rd_dvld_o  = rd_dvld_q;
    // The SRAM registers its address, so its output already lines up with
    // rd_dvld_o one cycle after the grant.
    assign rd_data_o  = mem_dout_i;
    assign frm_rdy_o  = frm_rdy_q;
    assign bank_sel_o = bank_sel_q;

endmodule

// File: doc/sram_pingpong_arb.md
SRAM_PINGPONG_ARB -- requirements
Module: sram_pingpong_arb

Interface
REQ-001 Parameter WD, default 8, pixel/data width.
REQ-002 Parameter FRAME, default 256*256, words per frame buffer (power of two).
REQ-003 Parameter WF, default $clog2(FRAME), frame-local address width; memory address width is WF+1.
REQ-004 clk  input  1  single clock, all logic on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 wr_vld  input  1  write stream pixel valid.
REQ-007 wr_rdy  output  1  write stream accepted this cycle (grant).
REQ-008 wr_data  input  WD  write stream pixel, raster order.
REQ-009 rd_req  input  1  reader access request.
REQ-010 rd_addr  input  WF  reader frame-local address.
REQ-011 rd_gnt  output  1  reader request granted this cycle.
REQ-012 rd_data  output  WD  read data, valid when rd_dvld=1.
REQ-013 rd_dvld  output  1  read data valid, one cycle after rd_gnt.
REQ-014 rd_frame_done  input  1  one-cycle pulse, reader finished with current read frame.
REQ-015 frm_rdy  output  1  read bank holds a complete frame.
REQ-016 bank_sel  output  1  current write bank; read bank is ~bank_sel.
REQ-017 mem_cs, mem_we  output  1 each  single-port SRAM chip select / write enable.
REQ-018 mem_addr  output  WF+1  SRAM address {bank, local address}.
REQ-019 mem_din  output  WD  SRAM write data.
REQ-020 mem_dout  input  WD  SRAM read data (registered-address SRAM, data valid the cycle after access).

Function
REQ-021 At most one SRAM access per cycle; mem_cs = wr_rdy | rd_gnt; wr_rdy and rd_gnt never both 1.
REQ-022 Write eligible when wr_vld=1 and write counter wcnt < FRAME; read eligible when rd_req=1 and frm_rdy=1.
REQ-023 Only one eligible -> grant it; both eligible -> round-robin, grant the side not granted last time both contended; contention pointer resets to "read wins next".
REQ-024 Write grant: mem_we=1, mem_addr={bank_sel, wcnt[WF-1:0]}, mem_din=wr_data; wcnt increments next cycle.
REQ-025 Read grant: mem_we=0, mem_addr={~bank_sel, rd_addr}; rd_dvld=1 next cycle with rd_data=mem_dout.
REQ-026 No grant: mem_cs=0, mem_we=0; mem_addr/mem_din don't-care.
REQ-027 Write side states FILL (wcnt<FRAME) and FULL (wcnt==FRAME); in FULL wr_rdy=0.
REQ-028 Swap when FULL and frm_rdy=0 (registered values): next cycle bank_sel toggles, wcnt=0, frm_rdy=1.
REQ-029 rd_frame_done with frm_rdy=1 clears frm_rdy next cycle; rd_frame_done with frm_rdy=0 ignored.
REQ-030 rd_frame_done and FULL same cycle: frm_rdy clears first, swap occurs the following cycle (one idle cycle between).
REQ-031 Write completing the frame (wcnt FRAME-1 -> FRAME) never swaps in the same cycle; earliest swap is next cycle.
REQ-032 Swap cycle grants no write (FULL) and may grant a read only from the old read bank.
REQ-033 rd_req while frm_rdy=0 -> rd_gnt=0, request stalls, no error.
REQ-034 wr_rdy, rd_gnt, mem_* combinational from registered state and inputs; rd_dvld, rd_data path registered/SRAM-latency as above.

Reset
REQ-035 rstn=0 at clock edge: bank_sel=0, wcnt=0, frm_rdy=0, rd_dvld=0, contention pointer=read-first.
REQ-036 Reset mid-frame discards partial frame and read-frame validity; first write after reset targets bank 0 address 0.
REQ-037 While rstn=0: wr_rdy=0, rd_gnt=0, mem_cs=0, mem_we=0.

Verification (FRAME=16 for simulation)
REQ-038 Reset, wr_vld=1 continuous 16 pixels 0..15 -> writes to mem_addr 0..15, cycle 17 FULL, cycle 18 bank_sel=1, frm_rdy=1.
REQ-039 After swap, rd_req with rd_addr=5 -> mem_addr=5 (bank 0), rd_dvld next cycle, rd_data=5.
REQ-040 wr_vld and rd_req both held after first swap -> grants alternate R,W,R,W; second-frame writes at mem_addr 16..31.
REQ-041 Second frame FULL while frm_rdy=1 -> wr_rdy stays 0; rd_frame_done pulse -> frm_rdy=0 next cycle, swap cycle after, bank_sel=0.
REQ-042 rstn=0 for one cycle at wcnt=7 -> bank_sel=0, frm_rdy=0; next write at mem_addr 0.
REQ-043 rd_req with frm_rdy=0 for 10 cycles -> rd_gnt=0, rd_dvld=0, mem_cs=0 throughout (no wr_vld).
